// File: rtl/hw_regs_pkg.sv
// Shared register map, bus response payload and UART serializer state encoding
// for the hw_regs peripheral block.
package hw_regs_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned TAG_W  = 9;
  localparam int unsigned SEG_W  = 24;
  localparam int unsigned LED_W  = 10;
  localparam int unsigned SW_W   = 10;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned IDX_W  = ADDR_W - 2;

  localparam logic [ADDR_W-1:0] OFF_SEVEN_SEG = 16'h0000;
  localparam logic [ADDR_W-1:0] OFF_LEDR      = 16'h0004;
  localparam logic [ADDR_W-1:0] OFF_SW        = 16'h0008;
  localparam logic [ADDR_W-1:0] OFF_KEY       = 16'h000C;
  localparam logic [ADDR_W-1:0] OFF_UART_TX   = 16'h0010;
  localparam logic [ADDR_W-1:0] OFF_TIMER     = 16'h0014;

  // Word indices: the byte-within-word address bits never take part in decode
  localparam logic [IDX_W-1:0] IDX_SEVEN_SEG = OFF_SEVEN_SEG[ADDR_W-1:2];
  localparam logic [IDX_W-1:0] IDX_LEDR      = OFF_LEDR[ADDR_W-1:2];
  localparam logic [IDX_W-1:0] IDX_SW        = OFF_SW[ADDR_W-1:2];
  localparam logic [IDX_W-1:0] IDX_KEY       = OFF_KEY[ADDR_W-1:2];
  localparam logic [IDX_W-1:0] IDX_UART_TX   = OFF_UART_TX[ADDR_W-1:2];
  localparam logic [IDX_W-1:0] IDX_TIMER     = OFF_TIMER[ADDR_W-1:2];

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] data;
  } hwregs_rsp_t;

  function automatic logic [WORD_W-1:0] apply_wmask(input logic [WORD_W-1:0] old_v,
                                                    input logic [WORD_W-1:0] new_v,
                                                    input logic [MASK_W-1:0] mask);
    logic [WORD_W-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (mask[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hw_regs_uart_tx_fifo.sv
// UART transmit path: byte FIFO with sticky overflow feeding an 8N1 serializer.
module uart_tx_fifo
  import hw_regs_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  input  logic        i_clr_ovf,
  output logic [15:0] o_free_c,
  output logic        o_overflow,
  output logic        o_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic          r_overflow;

  ser_state_e    r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_tx, w_tx_next;
  logic          w_pop;

  logic          w_empty, w_full, w_push_ok, w_bit_done;
  logic [PW-1:0] w_count;
  logic [7:0]    w_head;

  // Extra pointer MSB distinguishes full from empty when the indices coincide
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_count    = r_wptr - r_rptr;
  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_push_ok  = i_push && (!w_full || w_pop);
  assign w_bit_done = (r_cnt == CW'(CLKS_PER_BIT - 1));

  assign o_free_c   = 16'(FIFO_DEPTH) - 16'(w_count);
  assign o_overflow = r_overflow;
  assign o_tx       = r_tx;

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  // A dropped push in the same cycle as a clearing read leaves overflow set
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
      else if (i_clr_ovf)       r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SER_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SER_IDLE:  if (!w_empty) w_state_next = SER_START;
      SER_START: if (w_bit_done) w_state_next = SER_DATA;
      SER_DATA:  if (w_bit_done && (r_bit == 3'd7)) w_state_next = SER_STOP;
      SER_STOP:  if (w_bit_done) w_state_next = w_empty ? SER_IDLE : SER_START;
      default:   w_state_next = SER_IDLE;
    endcase
  end

  // Line level is set one edge ahead so every bit is exactly CLKS_PER_BIT wide
  always_comb begin
    w_pop        = 1'b0;
    w_cnt_next   = r_cnt + CW'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    case (r_state)
      SER_IDLE: begin
        w_cnt_next = '0;
        w_tx_next  = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_tx_next    = 1'b0;
        end
      end
      SER_START: begin
        if (w_bit_done) begin
          w_cnt_next = '0;
          w_bit_next = '0;
          w_tx_next  = r_shift[0];
        end
      end
      SER_DATA: begin
        if (w_bit_done) begin
          w_cnt_next = '0;
          if (r_bit == 3'd7) begin
            w_tx_next = 1'b1;
          end else begin
            w_bit_next   = r_bit + 3'd1;
            w_shift_next = r_shift >> 1;
            w_tx_next    = r_shift[1];
          end
        end
      end
      SER_STOP: begin
        if (w_bit_done) begin
          w_cnt_next = '0;
          w_tx_next  = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_tx_next    = 1'b0;
          end
        end
      end
      default: begin
        w_cnt_next = '0;
        w_tx_next  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/hw_regs.sv
// Memory-mapped board peripherals: seven-seg, LEDs, switches, keys, free-running
// timer and a buffered UART transmitter, with single-cycle tagged read responses.
module hw_regs
  import hw_regs_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hwregs_request,
  input  logic              hwregs_write,
  input  logic [ADDR_W-1:0] hwregs_address,
  input  logic [MASK_W-1:0] hwregs_wmask,
  input  logic [WORD_W-1:0] hwregs_wdata,
  input  logic [TAG_W-1:0]  hwregs_tag,
  output logic              hwregs_rvalid,
  output logic [TAG_W-1:0]  hwregs_rtag,
  output logic [WORD_W-1:0] hwregs_rdata,
  output logic [SEG_W-1:0]  seven_seg,
  output logic [LED_W-1:0]  ledr,
  input  logic [SW_W-1:0]   sw,
  input  logic [KEY_W-1:0]  key,
  output logic              uart_tx
);

  logic [SEG_W-1:0]  r_seven_seg;
  logic [LED_W-1:0]  r_ledr;
  logic [WORD_W-1:0] r_timer;
  logic [SW_W-1:0]   r_sw_meta, r_sw_sync;
  logic [KEY_W-1:0]  r_key_meta, r_key_sync;
  logic              r_rvalid;
  hwregs_rsp_t       r_rsp, w_rsp;

  logic [IDX_W-1:0]  w_word;
  logic              w_rd, w_wr;
  logic [WORD_W-1:0] w_rdata;
  logic [15:0]       w_uart_free;
  logic              w_uart_ovf;
  logic              w_unused_addr;

  assign w_word        = hwregs_address[ADDR_W-1:2];
  assign w_unused_addr = ^hwregs_address[1:0];
  assign w_rd          = hwregs_request && !hwregs_write;
  assign w_wr          = hwregs_request && hwregs_write;

  assign seven_seg     = r_seven_seg;
  assign ledr          = r_ledr;
  assign hwregs_rvalid = r_rvalid;
  assign hwregs_rtag   = r_rsp.tag;
  assign hwregs_rdata  = r_rsp.data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_key_meta <= '0;
      r_key_sync <= '0;
    end else begin
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
      r_key_meta <= key;
      r_key_sync <= r_key_meta;
    end
  end

  // A timer write takes priority over that cycle's increment
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seven_seg <= '0;
      r_ledr      <= '0;
      r_timer     <= '0;
    end else begin
      if (w_wr && (w_word == IDX_SEVEN_SEG))
        r_seven_seg <= SEG_W'(apply_wmask(WORD_W'(r_seven_seg), hwregs_wdata, hwregs_wmask));
      if (w_wr && (w_word == IDX_LEDR))
        r_ledr <= LED_W'(apply_wmask(WORD_W'(r_ledr), hwregs_wdata, hwregs_wmask));
      if (w_wr && (w_word == IDX_TIMER))
        r_timer <= apply_wmask(r_timer, hwregs_wdata, hwregs_wmask);
      else
        r_timer <= r_timer + 32'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_word)
      IDX_SEVEN_SEG: w_rdata = WORD_W'(r_seven_seg);
      IDX_LEDR:      w_rdata = WORD_W'(r_ledr);
      IDX_SW:        w_rdata = WORD_W'(r_sw_sync);
      IDX_KEY:       w_rdata = WORD_W'(r_key_sync);
      IDX_UART_TX:   w_rdata = {15'd0, w_uart_ovf, w_uart_free};
      IDX_TIMER:     w_rdata = r_timer;
      default:       w_rdata = '0;
    endcase
  end

  always_comb begin
    w_rsp = '0;
    if (w_rd) begin
      w_rsp.tag  = hwregs_tag;
      w_rsp.data = w_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rsp    <= '0;
    end else begin
      r_rvalid <= w_rd;
      r_rsp    <= w_rsp;
    end
  end

  uart_tx_fifo #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_wr && (w_word == IDX_UART_TX) && hwregs_wmask[0]),
    .i_data     (hwregs_wdata[7:0]),
    .i_clr_ovf  (w_rd && (w_word == IDX_UART_TX)),
    .o_free_c   (w_uart_free),
    .o_overflow (w_uart_ovf),
    .o_tx       (uart_tx)
  );

endmodule

// File: tb/tb_hw_regs.sv
// Directed bench for hw_regs: read responses are scoreboarded against a queue of
// expected {tag,data}; register, timer and UART line behaviour checked inline.
module tb_hw_regs;
  import hw_regs_pkg::*;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              hwregs_request = 1'b0;
  logic              hwregs_write = 1'b0;
  logic [ADDR_W-1:0] hwregs_address = '0;
  logic [MASK_W-1:0] hwregs_wmask = '0;
  logic [WORD_W-1:0] hwregs_wdata = '0;
  logic [TAG_W-1:0]  hwregs_tag = '0;
  logic              hwregs_rvalid;
  logic [TAG_W-1:0]  hwregs_rtag;
  logic [WORD_W-1:0] hwregs_rdata;
  logic [SEG_W-1:0]  seven_seg;
  logic [LED_W-1:0]  ledr;
  logic [SW_W-1:0]   sw = '0;
  logic [KEY_W-1:0]  key = '0;
  logic              uart_tx;

  typedef struct {
    int unsigned       due;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] data;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  hw_regs #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .hwregs_request (hwregs_request),
    .hwregs_write   (hwregs_write),
    .hwregs_address (hwregs_address),
    .hwregs_wmask   (hwregs_wmask),
    .hwregs_wdata   (hwregs_wdata),
    .hwregs_tag     (hwregs_tag),
    .hwregs_rvalid  (hwregs_rvalid),
    .hwregs_rtag    (hwregs_rtag),
    .hwregs_rdata   (hwregs_rdata),
    .seven_seg      (seven_seg),
    .ledr           (ledr),
    .sw             (sw),
    .key            (key),
    .uart_tx        (uart_tx)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    hwregs_request = 1'b0;
    hwregs_write   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    hwregs_request = 1'b1;
    hwregs_write   = 1'b1;
    hwregs_address = a;
    hwregs_wdata   = d;
    hwregs_wmask   = m;
    hwregs_tag     = '0;
    tick();
    hwregs_request = 1'b0;
    hwregs_write   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] t, input logic [31:0] exp);
    exp_t e;
    e.due  = cyc + 1;
    e.tag  = t;
    e.data = exp;
    q.push_back(e);
    hwregs_request = 1'b1;
    hwregs_write   = 1'b0;
    hwregs_address = a;
    hwregs_tag     = t;
    hwregs_wmask   = '0;
    hwregs_wdata   = '0;
    tick();
    hwregs_request = 1'b0;
  endtask

  // Response monitor: expected entries come due exactly one cycle after issue
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      while (q.size() != 0 && q[0].due < cyc) begin
        e = q.pop_front();
        check("rsp_missing_due", cyc, e.due);
      end
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("rvalid", 32'(hwregs_rvalid), 32'd1);
        check("rtag", 32'(hwregs_rtag), 32'(e.tag));
        check("rdata", hwregs_rdata, e.data);
      end else begin
        check("rvalid_idle", 32'(hwregs_rvalid), 32'd0);
        check("rtag_idle", 32'(hwregs_rtag), 32'd0);
        check("rdata_idle", hwregs_rdata, 32'd0);
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [9:0] frame;
    logic       exp_bit;

    repeat (3) tick();
    check("rst_seven_seg", 32'(seven_seg), 32'd0);
    check("rst_ledr", 32'(ledr), 32'd0);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_rvalid", 32'(hwregs_rvalid), 32'd0);
    check("rst_rdata", hwregs_rdata, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(1);

    wr(OFF_LEDR, 32'h0000_03FF, 4'hF);
    rd(OFF_LEDR, 9'h005, 32'h0000_03FF);
    check("ledr_full", 32'(ledr), 32'h3FF);

    wr(OFF_SEVEN_SEG, 32'h00AB_CDEF, 4'h2);
    check("seg_lane1", 32'(seven_seg), 32'h0000_CD00);
    rd(OFF_SEVEN_SEG, 9'h01A, 32'h0000_CD00);
    wr(OFF_SEVEN_SEG, 32'hFFFF_FFFF, 4'hC);
    check("seg_lane23", 32'(seven_seg), 32'h00FF_CD00);
    rd(OFF_SEVEN_SEG, 9'h1B0, 32'h00FF_CD00);

    // Lane 1 carries 0xFE; only its low two bits land in ledr[9:8]
    wr(OFF_LEDR, 32'h0000_FE00, 4'h2);
    check("ledr_lane1", 32'(ledr), 32'h2FF);
    rd(16'h0005, 9'h0C3, 32'h0000_02FF);

    wr(OFF_SW, 32'hFFFF_FFFF, 4'hF);
    wr(16'h0018, 32'hFFFF_FFFF, 4'hF);
    check("ledr_untouched", 32'(ledr), 32'h2FF);
    rd(16'h0018, 9'h011, 32'h0);
    rd(16'h0100, 9'h012, 32'h0);

    sw  = 10'h2A5;
    key = 4'h9;
    idle(3);
    rd(OFF_SW, 9'h1FF, 32'h0000_02A5);
    rd(OFF_KEY, 9'h100, 32'h0000_0009);
    sw = 10'h155;
    rd(OFF_SW, 9'h021, 32'h0000_02A5);
    rd(OFF_SW, 9'h022, 32'h0000_02A5);
    rd(OFF_SW, 9'h023, 32'h0000_0155);

    // Load, then two increments carry it through the wrap
    wr(OFF_TIMER, 32'hFFFF_FFFE, 4'hF);
    idle(2);
    rd(OFF_TIMER, 9'h030, 32'h0);
    wr(OFF_TIMER, 32'h1234_5678, 4'h3);
    rd(OFF_TIMER, 9'h031, 32'h0000_5678);
    rd(OFF_TIMER, 9'h032, 32'h0000_5679);

    wr(OFF_UART_TX, 32'h0000_00AA, 4'hE);
    rd(OFF_UART_TX, 9'h040, 32'h0000_0010);
    idle(2);

    d = 8'h55;
    frame = {1'b1, d, 1'b0};
    wr(OFF_UART_TX, 32'(d), 4'h1);
    check("uart_pre_pop", 32'(uart_tx), 32'd1);
    for (int s = 1; s <= 44; s++) begin
      tick();
      exp_bit = (s <= 40) ? frame[(s - 1) / 4] : 1'b1;
      check($sformatf("uart_bit_s%0d", s), 32'(uart_tx), 32'(exp_bit));
    end
    rd(OFF_UART_TX, 9'h041, 32'h0000_0010);

    for (int i = 0; i < 18; i++) wr(OFF_UART_TX, 32'(8'h10 + 8'(i)), 4'h1);
    rd(OFF_UART_TX, 9'h042, 32'h0001_0000);
    rd(OFF_UART_TX, 9'h043, 32'h0000_0000);
    d = 8'h10;
    check("uart_data_bit3", 32'(uart_tx), 32'(d[3]));

    // Reset in DATA bit 3 with a read in flight: that read must not answer
    reset          = 1'b1;
    hwregs_request = 1'b1;
    hwregs_write   = 1'b0;
    hwregs_address = OFF_UART_TX;
    hwregs_tag     = 9'h0EE;
    tick();
    hwregs_request = 1'b0;
    check("rst_mid_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_mid_ledr", 32'(ledr), 32'd0);
    check("rst_mid_seg", 32'(seven_seg), 32'd0);
    reset = 1'b0;
    rd(OFF_UART_TX, 9'h044, 32'h0000_0010);
    rd(OFF_TIMER, 9'h045, 32'h0000_0001);
    for (int s = 0; s < 12; s++) begin
      check("uart_idle_after_rst", 32'(uart_tx), 32'd1);
      tick();
    end

    idle(2);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
